// File: rtl/qqspi_arbiter.sv
// rtl/qqspi_arbiter.sv - two-requester arbiter in front of a shared QSPI memory controller
// One transaction in flight at a time; the winner's request is latched and held until the controller completes.
module qqspi_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [22:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [22:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [22:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, DRAIN = 2'b10} state_t;

  state_t      state_q, state_d;
  logic        s_valid_q, s_valid_d;
  logic [22:0] s_addr_q, s_addr_d;
  logic [31:0] s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [1:0]  grant_q, grant_d;
  logic        busy_q, busy_d;
  logic        last_q, last_d;
  logic        m0_ready_q, m0_ready_d;
  logic        m1_ready_q, m1_ready_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        pick_m1;

  // last_q=1 means m1 was served last, so m0 takes the next tie.
  assign pick_m1 = m1_valid && (!m0_valid || (!FIXED_PRIO && !last_q));

  always_comb begin
    state_d    = state_q;
    s_valid_d  = s_valid_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d   = ISSUE;
          s_valid_d = 1'b1;
          grant_d   = pick_m1 ? 2'b10 : 2'b01;
          s_addr_d  = pick_m1 ? m1_addr : m0_addr;
          s_wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          s_wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
        end
      end
      ISSUE: begin
        if (s_ready) begin
          state_d   = DRAIN;
          s_valid_d = 1'b0;
          if (grant_q[1]) begin
            m1_ready_d = 1'b1;
            m1_rdata_d = s_rdata;
          end else begin
            m0_ready_d = 1'b1;
            m0_rdata_d = s_rdata;
          end
        end
      end
      DRAIN: begin
        // The controller keeps s_ready high until it sees s_valid low; never reissue before it lets go.
        if (!s_ready) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = grant_q[1];
        end
      end
      default: begin
        state_d   = IDLE;
        s_valid_d = 1'b0;
        grant_d   = 2'b00;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      s_valid_q  <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      grant_q    <= 2'b00;
      busy_q     <= 1'b0;
      last_q     <= 1'b1;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      s_valid_q  <= s_valid_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wstrb  = s_wstrb_q;
  assign grant    = grant_q;
  assign busy     = busy_q;
  assign m0_ready = m0_ready_q;
  assign m1_ready = m1_ready_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
endmodule
